// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR input feeder and FIR datapath.
package fir_pkg;

   localparam int unsigned FIR_WIDTH = 16;

   typedef enum logic [1:0] {
      FEED_IDLE,
      FEED_ISSUE,
      FEED_WAIT
   } fir_feed_state_t;

endpackage

// File: rtl/fir_input_feeder_if.sv
// Source stream and FIR-side handshake bundle for the input feeder.
interface fir_input_feeder_if
   import fir_pkg::*;
#(
   parameter int unsigned WIDTH = FIR_WIDTH
);
   logic signed [WIDTH-1:0] s_data;
   logic                    s_valid;
   logic                    s_ready;
   logic signed [WIDTH-1:0] fir_input;
   logic                    fir_input_valid;
   logic                    fir_output_valid;

   modport master (
      output s_data, s_valid, fir_output_valid,
      input  s_ready, fir_input, fir_input_valid
   );

   modport slave (
      input  s_data, s_valid, fir_output_valid,
      output s_ready, fir_input, fir_input_valid
   );
endinterface

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO with flush; only pointers and count are reset.
module fir_sample_fifo #(
   parameter  int unsigned WIDTH = 16,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W:0]   cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == (PTR_W+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign rdata   = mem[rptr];
   assign count   = cnt;
   // Full refuses a push even with a simultaneous pop; flush wins over push.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_W'(1);
         if (do_pop)  rptr <= rptr + PTR_W'(1);
         cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end
endmodule

// File: rtl/fir_input_feeder.sv
// Buffers source samples and paces them to the FIR one at a time, waiting for
// completion (or a timeout) before issuing the next sample.
module fir_input_feeder
   import fir_pkg::*;
#(
   parameter  int unsigned WIDTH   = FIR_WIDTH,
   parameter  int unsigned DEPTH   = 16,
   parameter  int unsigned TIMEOUT = 256,
   localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   fir_input_feeder_if.slave  bus,
   output logic [PTR_W:0]     fill_level,
   output logic               busy,
   output logic               err_timeout
);
   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

   fir_feed_state_t  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_d;
   logic             pop;
   logic             push;
   logic             active_q;
   logic             valid_q;
   logic [WIDTH-1:0] fir_input_q;
   logic [WIDTH-1:0] head;
   logic             full;
   logic             empty;

   // active_q keeps s_ready low during reset and until the first edge after it.
   assign bus.s_ready         = active_q && !full;
   assign push                = bus.s_valid && bus.s_ready;
   assign bus.fir_input       = fir_input_q;
   assign bus.fir_input_valid = valid_q;

   fir_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (bus.s_data),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fill_level)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_timeout;
      pop     = 1'b0;
      case (state_q)
         FEED_IDLE: begin
            if (!empty) begin
               state_d = FEED_ISSUE;
               pop     = 1'b1;
            end
         end
         FEED_ISSUE: begin
            state_d = FEED_WAIT;
            cnt_d   = '0;
         end
         FEED_WAIT: begin
            if (bus.fir_output_valid) begin
               state_d = FEED_IDLE;
            end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = FEED_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = FEED_IDLE;
      endcase
   end

   // Strobe and busy are registered from the next state so they track state exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FEED_IDLE;
         cnt_q       <= '0;
         err_timeout <= 1'b0;
         active_q    <= 1'b0;
         valid_q     <= 1'b0;
         busy        <= 1'b0;
         fir_input_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_timeout <= err_d;
         active_q    <= 1'b1;
         valid_q     <= (state_d == FEED_ISSUE);
         busy        <= (state_d != FEED_IDLE);
         if (pop) fir_input_q <= head;
      end
   end
endmodule

// File: tb/tb_fir_input_feeder.sv
// Scoreboard bench for fir_input_feeder: long-timeout instance a, short-timeout instance b.
module tb_fir_input_feeder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush_a = 1'b0;
   logic       flush_b = 1'b0;
   logic [4:0] fill_a, fill_b;
   logic       busy_a, busy_b, err_a, err_b;

   fir_input_feeder_if #(.WIDTH(16)) a ();
   fir_input_feeder_if #(.WIDTH(16)) b ();

   fir_input_feeder #(.WIDTH(16), .DEPTH(16), .TIMEOUT(256)) dut_a (
      .clk(clk), .rst(rst), .flush(flush_a), .bus(a),
      .fill_level(fill_a), .busy(busy_a), .err_timeout(err_a)
   );

   fir_input_feeder #(.WIDTH(16), .DEPTH(16), .TIMEOUT(8)) dut_b (
      .clk(clk), .rst(rst), .flush(flush_b), .bus(b),
      .fill_level(fill_b), .busy(busy_b), .err_timeout(err_b)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] sbq[$];

   // Edge counter and the edge at which the FIR last reported completion.
   int cyc = 0;
   int last_ov = -100;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (a.fir_output_valid === 1'b1) last_ov = cyc;
   end

   // Strobe monitor: records every fir_input_valid cycle on instance a.
   logic [15:0] obs_data [64];
   int          obs_cyc  [64];
   int          obs_ov   [64];
   int          obs_wr = 0;
   int          dbl = 0;
   bit          prev_v = 1'b0;
   always @(negedge clk) begin
      if (a.fir_input_valid === 1'b1) begin
         if (prev_v) dbl = dbl + 1;
         if (obs_wr < 64) begin
            obs_data[obs_wr] = a.fir_input;
            obs_cyc[obs_wr]  = cyc;
            obs_ov[obs_wr]   = last_ov;
            obs_wr = obs_wr + 1;
         end
      end
      prev_v = (a.fir_input_valid === 1'b1);
   end

   // FIR model: completes lat cycles after a strobe when auto_resp, or on a kick.
   bit auto_resp = 1'b0;
   int lat = 70;
   int kick_req = 0;
   int kick_ack = 0;
   int resp_cnt = 0;
   always @(negedge clk) begin
      logic fov;
      fov = 1'b0;
      if (kick_req != kick_ack) begin
         fov = 1'b1;
         kick_ack = kick_req;
      end
      if (resp_cnt > 0) begin
         resp_cnt = resp_cnt - 1;
         if (resp_cnt == 0) fov = 1'b1;
      end
      if (auto_resp && a.fir_input_valid === 1'b1) resp_cnt = lat;
      if (rst) resp_cnt = 0;
      a.fir_output_valid = fov;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int obs_rd = 0;
   int push_edge = 0;

   task automatic push_a(input logic [15:0] d, input int budget, output bit ok);
      a.s_data  = d;
      a.s_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (a.s_ready === 1'b1) begin
            ok = 1'b1;
            push_edge = cyc + 1;
            sbq.push_back(d);
         end
         @(negedge clk);
      end
      a.s_valid = 1'b0;
   endtask

   task automatic wait_strobes(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && obs_wr < target; i++) @(negedge clk);
      check(tag, 32'(obs_wr), 32'(target));
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget && (busy_a !== 1'b0 || fill_a !== 5'd0); i++) @(negedge clk);
      check({tag, "_busy"}, 32'(busy_a), 32'd0);
      check({tag, "_fill"}, 32'(fill_a), 32'd0);
   endtask

   task automatic compare_strobes();
      while (obs_rd < obs_wr) begin
         if (sbq.size() == 0) check("sb_underflow", 32'(sbq.size()), 32'd1);
         else check("fir_input", 32'(obs_data[obs_rd]), 32'(sbq.pop_front()));
         obs_rd = obs_rd + 1;
      end
   endtask

   initial begin
      bit ok;
      int base;
      a.s_valid = 1'b0; a.s_data = '0;
      b.s_valid = 1'b0; b.s_data = '0; b.fir_output_valid = 1'b0;

      // Reset values while rst is held, then idle after release.
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(a.s_ready), 32'd0);
      check("rst_valid", 32'(a.fir_input_valid), 32'd0);
      check("rst_fir_input", 32'(a.fir_input), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_ready", 32'(a.s_ready), 32'd1);
      check("idle_fill", 32'(fill_a), 32'd0);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_no_strobe", 32'(obs_wr), 32'd0);

      // Three boundary samples with a 70-cycle FIR.
      auto_resp = 1'b1; lat = 70; base = obs_wr;
      push_a(16'h7FFF, 5, ok); check("t2_push0", 32'(ok), 32'd1);
      base = push_edge;
      push_a(16'h8000, 5, ok); check("t2_push1", 32'(ok), 32'd1);
      push_a(16'h0001, 5, ok); check("t2_push2", 32'(ok), 32'd1);
      wait_drain("t2_drain", 600);
      check("t2_strobes", 32'(obs_wr), 32'd3);
      check("t2_latency", 32'(obs_cyc[0] - base), 32'd1);
      for (int i = 1; i < 3; i++) check("t2_gap", 32'(obs_cyc[i] - obs_ov[i]), 32'd1);
      compare_strobes();

      // Fill to full while FIR withholds completion.
      auto_resp = 1'b0; base = obs_wr;
      push_a(16'h0100, 5, ok);
      wait_strobes("t3_first_issue", base + 1, 10);
      for (int i = 1; i < 16; i++) push_a(16'h0100 + 16'(i), 5, ok);
      check("t3_fill15", 32'(fill_a), 32'd15);
      push_a(16'h0110, 5, ok);
      check("t3_fill16", 32'(fill_a), 32'd16);
      check("t3_ready_full", 32'(a.s_ready), 32'd0);
      push_a(16'h0111, 6, ok);
      check("t3_stall", 32'(ok), 32'd0);
      check("t3_fill_hold", 32'(fill_a), 32'd16);
      auto_resp = 1'b1; lat = 4; kick_req = kick_req + 1;
      push_a(16'h0111, 60, ok);
      check("t3_late_push", 32'(ok), 32'd1);
      wait_drain("t3_drain", 2000);
      check("t3_strobes", 32'(obs_wr - base), 32'd18);
      compare_strobes();

      // Timeout on instance b.
      check("t4_ready", 32'(b.s_ready), 32'd1);
      b.s_data = 16'h0AAA; b.s_valid = 1'b1;
      @(negedge clk);
      b.s_valid = 1'b0;
      for (int i = 0; i < 10 && b.fir_input_valid !== 1'b1; i++) @(negedge clk);
      check("t4_issue", 32'(b.fir_input_valid), 32'd1);
      check("t4_data0", 32'(b.fir_input), 32'h0AAA);
      b.s_data = 16'h0BBB; b.s_valid = 1'b1;
      @(negedge clk);
      b.s_valid = 1'b0;
      repeat (7) @(negedge clk);
      check("t4_err_before", 32'(err_b), 32'd0);
      @(negedge clk);
      check("t4_err_set", 32'(err_b), 32'd1);
      check("t4_no_strobe", 32'(b.fir_input_valid), 32'd0);
      @(negedge clk);
      check("t4_next_issue", 32'(b.fir_input_valid), 32'd1);
      check("t4_data1", 32'(b.fir_input), 32'h0BBB);
      check("t4_err_sticky", 32'(err_b), 32'd1);

      // Flush with a simultaneous push while WAIT is in flight.
      auto_resp = 1'b0; base = obs_wr;
      push_a(16'h0500, 5, ok);
      wait_strobes("t5_issue", base + 1, 10);
      compare_strobes();
      for (int i = 1; i < 6; i++) push_a(16'h0500 + 16'(i), 5, ok);
      check("t5_fill5", 32'(fill_a), 32'd5);
      flush_a = 1'b1; a.s_data = 16'h05FF; a.s_valid = 1'b1;
      @(negedge clk);
      flush_a = 1'b0; a.s_valid = 1'b0;
      sbq.delete();
      check("t5_fill0", 32'(fill_a), 32'd0);
      check("t5_busy", 32'(busy_a), 32'd1);
      kick_req = kick_req + 1;
      repeat (3) @(negedge clk);
      check("t5_done", 32'(busy_a), 32'd0);
      repeat (10) @(negedge clk);
      check("t5_no_strobe", 32'(obs_wr - base), 32'd1);
      check("t5_fill_after", 32'(fill_a), 32'd0);

      // Asynchronous reset in WAIT with samples queued.
      base = obs_wr;
      push_a(16'h0600, 5, ok);
      wait_strobes("t6_issue", base + 1, 10);
      compare_strobes();
      for (int i = 1; i < 5; i++) push_a(16'h0600 + 16'(i), 5, ok);
      check("t6_fill4", 32'(fill_a), 32'd4);
      #1 rst = 1'b1;
      #1;
      check("t6_rst_fill", 32'(fill_a), 32'd0);
      check("t6_rst_busy", 32'(busy_a), 32'd0);
      check("t6_rst_valid", 32'(a.fir_input_valid), 32'd0);
      check("t6_rst_data", 32'(a.fir_input), 32'd0);
      check("t6_rst_ready", 32'(a.s_ready), 32'd0);
      check("t6_rst_err_b", 32'(err_b), 32'd0);
      sbq.delete();
      base = obs_wr;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_no_strobe", 32'(obs_wr), 32'(base));
      check("t6_fill_after", 32'(fill_a), 32'd0);
      push_a(16'h1234, 5, ok);
      wait_strobes("t6_new_issue", base + 1, 10);
      check("t6_latency", 32'(obs_cyc[base] - push_edge), 32'd1);
      compare_strobes();
      kick_req = kick_req + 1;
      wait_drain("t6_drain", 50);
      check("t6_strobes", 32'(obs_wr - base), 32'd1);

      check("one_cycle_strobes", 32'(dbl), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
